// File: rtl/sensor_frame_tx.sv
// -----------------------------------------------------------------------------
// sensor_frame_tx
//
// Upstream feeder for uart_tx. It snapshots the 4-bit food level (peso) and
// the 4-bit water level (agua) and sends them as a framed, checksummed 5-byte
// ASCII packet:
//
//   '{'  H(peso)  H(agua)  H(peso ^ agua)  '}'
//
// H(n) is the ASCII hex digit of n ('0'..'9', 'A'..'F'). A frame is requested
// periodically (AUTO=1, every PERIOD cycles) and/or on demand by send_now.
// Requests collapse into a single pending flag; there is no queue.
//
// Parameters:
//   PERIOD     clk cycles between automatic frame requests (>= 2)
//   AUTO       1 = periodic frames enabled, 0 = only send_now triggers frames
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   peso       food level (4 bits)
//   agua       water level (4 bits)
//   send_now   single-cycle request for an immediate frame
//   tx_ready   uart_tx ready: 1 = idle and accepting a byte
//   tx_start   one-cycle strobe to uart_tx.start
//   tx_data    byte to uart_tx.data, held until the byte completes
//   busy       high from frame snapshot until the final byte completes
//   frame_done one-cycle pulse after the 5th byte completes
// -----------------------------------------------------------------------------
module sensor_frame_tx #(
    parameter int PERIOD = 12000000,
    parameter bit AUTO   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] peso,
    input  logic [3:0] agua,
    input  logic       send_now,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [2:0] LAST_INDEX = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_READY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] period_cnt;
    logic             pending;
    logic [2:0]       index;
    logic [3:0]       peso_s;
    logic [3:0]       agua_s;

    logic             period_hit;
    logic             request;
    logic             depart;

    // ASCII hex digit of a nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Byte at position idx of the frame built from the snapshot values.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [3:0] p,
                                              input logic [3:0] a);
        case (idx)
            3'd0:    return 8'h7B;
            3'd1:    return hex_ascii(p);
            3'd2:    return hex_ascii(a);
            3'd3:    return hex_ascii(p ^ a);
            default: return 8'h7D;
        endcase
    endfunction

    assign period_hit = AUTO && (period_cnt == CNT_LAST);
    assign request    = send_now || period_hit;
    assign depart     = (state == IDLE) && pending;

    // Free-running period counter; keeps counting while a frame is in flight
    // so the frame rate does not drift with UART timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (AUTO) begin
            if (period_hit)
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + CNT_W'(1);
        end else begin
            period_cnt <= '0;
        end
    end

    // A request arriving in the same cycle as the IDLE->LOAD departure wins,
    // leaving pending set for exactly one follow-up frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else
            pending <= (pending && !depart) || request;
    end

    // Level snapshot; only taken in LOAD so mid-frame input changes are not
    // seen by the frame being sent.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            peso_s <= peso;
            agua_s <= agua;
        end
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            index      <= 3'd0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (pending)
                        state <= LOAD;
                end
                LOAD: begin
                    index <= 3'd0;
                    busy  <= 1'b1;
                    state <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_data  <= frame_byte(index, peso_s, agua_s);
                        tx_start <= 1'b1;
                        state    <= WAIT_BUSY;
                    end
                end
                // uart_tx drops ready once it has taken the byte; waiting for
                // that edge keeps a stale ready from triggering the next byte.
                WAIT_BUSY: begin
                    if (!tx_ready)
                        state <= WAIT_READY;
                end
                WAIT_READY: begin
                    if (tx_ready) begin
                        if (index == LAST_INDEX) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            index <= index + 3'd1;
                            state <= SEND;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_sensor_frame_tx
//
// Directed testbench for sensor_frame_tx with a behavioural uart_tx model
// (ready drops on the edge that sees tx_start, returns char_cycles later).
// -----------------------------------------------------------------------------
module tb_sensor_frame_tx;

    localparam int PERIOD = 1000;

    logic       clk;
    logic       rst;
    logic [3:0] peso;
    logic [3:0] agua;
    logic       send_now;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // uart model state and monitors
    logic       m_ready;
    int         m_cnt;
    int         char_cycles = 20;
    logic       hold_low = 1'b0;
    logic       prev_start;
    logic [7:0] bytes[$];
    int         t_first[$];
    int         n_start;
    int         n_fd;
    int         viol = 0;
    int         cyc = 0;

    sensor_frame_tx #(
        .PERIOD(PERIOD),
        .AUTO  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .peso      (peso),
        .agua      (agua),
        .send_now  (send_now),
        .tx_ready  (tx_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign tx_ready = m_ready && !hold_low;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready    <= 1'b1;
            m_cnt      <= 0;
            prev_start <= 1'b0;
            bytes.delete();
            t_first.delete();
            n_start = 0;
            n_fd    = 0;
        end else begin
            prev_start <= tx_start;
            if (frame_done) n_fd = n_fd + 1;
            if (tx_start) begin
                n_start = n_start + 1;
                if (prev_start || !tx_ready) viol = viol + 1;
                bytes.push_back(tx_data);
                if (tx_data == 8'h7B) t_first.push_back(cyc);
                m_ready <= 1'b0;
                m_cnt   <= char_cycles;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_ready <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_send();
        @(negedge clk);
        send_now = 1'b1;
        @(negedge clk);
        send_now = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (n_fd < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_fd < n) chk({tag, "_timeout"}, n_fd, n);
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (n_start < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_start < n) chk({tag, "_timeout"}, n_start, n);
    endtask

    task automatic chk_frame(input string tag, input int base, input logic [39:0] exp);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_b%0d", tag, i), bytes[base + i], exp[39 - 8 * i -: 8]);
    endtask

    task automatic single_frame(input string tag, input logic [3:0] p, input logic [3:0] a,
                                input logic [39:0] exp, input int chr);
        char_cycles = chr;
        peso = p;
        agua = a;
        do_reset();
        pulse_send();
        wait_fd(tag, 1, 900);
        chk_frame(tag, 0, exp);
        chk({tag, "_starts"}, n_start, 5);
        chk({tag, "_fd"}, n_fd, 1);
        @(negedge clk);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        peso     = 4'h0;
        agua     = 4'h0;
        send_now = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);

        // basic frames, 115200-baud-like uart for the first
        single_frame("f3a", 4'h3, 4'hA, 40'h7B_33_41_39_7D, 104);
        single_frame("fff", 4'hF, 4'hF, 40'h7B_46_46_30_7D, 20);
        single_frame("f09", 4'h0, 4'h9, 40'h7B_30_39_39_7D, 20);

        // periodic frames with a mid-frame peso change
        char_cycles = 20;
        peso = 4'h5;
        agua = 4'h2;
        do_reset();
        wait_starts("per", 2, 1200);
        peso = 4'hC;
        wait_fd("per", 2, 1300);
        chk_frame("per1", 0, 40'h7B_35_32_37_7D);
        chk_frame("per2", 5, 40'h7B_43_32_45_7D);
        chk("per_nfirst", t_first.size(), 2);
        chk("per_spacing", t_first[1] - t_first[0], PERIOD);

        // three requests during one busy frame -> one extra frame
        peso = 4'h1;
        agua = 4'h2;
        do_reset();
        pulse_send();
        repeat (4) @(negedge clk);
        chk("coll_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pulse_send();
            repeat (5) @(negedge clk);
        end
        wait_fd("coll", 2, 800);
        repeat (150) @(negedge clk);
        chk("coll_fd", n_fd, 2);
        chk("coll_starts", n_start, 10);
        chk("coll_busy_after", busy, 1'b0);

        // asynchronous reset in WAIT_READY at byte 2
        peso = 4'h3;
        agua = 4'hA;
        do_reset();
        pulse_send();
        wait_starts("ar", 3, 400);
        repeat (3) @(negedge clk);
        chk("ar_pre_busy", busy, 1'b1);
        chk("ar_pre_data", tx_data, 8'h41);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_tx_start", tx_start, 1'b0);
        chk("ar_tx_data", tx_data, 8'h00);
        chk("ar_busy", busy, 1'b0);
        chk("ar_frame_done", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (PERIOD - 10) @(negedge clk);
        chk("ar_idle_starts", n_start, 0);
        chk("ar_idle_busy", busy, 1'b0);

        // tx_ready held low before the first byte
        peso = 4'h0;
        agua = 4'h9;
        do_reset();
        hold_low = 1'b1;
        pulse_send();
        repeat (500) @(negedge clk);
        chk("hold_starts", n_start, 0);
        chk("hold_busy", busy, 1'b1);
        hold_low = 1'b0;
        wait_fd("hold", 1, 400);
        chk_frame("hold", 0, 40'h7B_30_39_39_7D);

        chk("protocol_violations", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
